hart_puls_gen: RTL
==================

Name: hart_puls_gen

Overview:
- Programmable heartbeat pulse generator: emits a periodic single-bit beat waveform that stands in for the heart-rate sensor.
- Output `beat` drives the input of the heartbeat counter, so the counter can be exercised on the board and in simulation without the physical sensor.
- Rate and pulse width are programmable at run time, with glitch-free changeover at beat boundaries.
- A wrapping beat counter allows cross-checking against the counter's windowed result.

Parameters:
- PER_W, 16, width of period counter/period register (clk cycles).
- DEF_PERIOD, 16'd1000, period loaded at reset (clk cycles between rising edges of beat).
- DEF_WIDTH, 8'd4, high time loaded at reset (clk cycles).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  level; 1 = generate beats, 0 = stop after current high phase.
- load  input  1  one-cycle strobe; capture period_in/width_in into shadow registers.
- period_in  input  PER_W  requested period in clk cycles.
- width_in  input  8  requested high time in clk cycles.
- beat  output  1  registered pulse output (to heartbeat counter input).
- beat_cnt  output  8  number of beats started since reset, wraps 255->0.
- busy  output  1  1 while state != IDLE.
- err  output  1  sticky: an illegal period/width was loaded and clamped.

Behaviour:
- Reset (async, any time incl. mid-pulse):
  - beat=0, beat_cnt=0, busy=0, err=0, state=IDLE, phase counter=0.
  - Shadow and active regs = DEF_PERIOD/DEF_WIDTH.
- Shadow load: on a clk edge with load=1, shadow_per<=period_in and shadow_wid<=width_in. A load while busy never alters the beat in progress.
- Clamping (applied when shadow is copied to active):
  - wid_eff = (shadow_wid==0) ? 1 : shadow_wid.
  - per_eff = (shadow_per <= wid_eff) ? wid_eff+1 : shadow_per.
  - If either clamp fires, err<=1 (sticky until reset).
- Active update: active_per/active_wid <= clamped shadow at every beat start (IDLE->HIGH, LOW->HIGH).
  - Load and beat start on the same edge: the incoming period_in/width_in (bypass) are used for the beat that starts on that edge.
- FSM states and transitions:
  - IDLE: beat=0. If en=1 at an edge -> HIGH, beat=1 after that edge, beat_cnt+1, phase counter <= 1.
  - HIGH: beat=1. When the counter reaches wid_eff -> LOW (beat=0 next edge). If en=0 here, the high phase still completes and the state then goes to IDLE instead of LOW.
  - LOW: beat=0. When the counter reaches per_eff -> HIGH (new beat, counter<=1, beat_cnt+1) if en=1. If en=0 -> IDLE immediately (LOW phase aborted).
- Timing:
  - Rising edges of beat are exactly per_eff cycles apart.
  - High time is exactly wid_eff cycles.
  - Latency from en rising (sampled) to beat=1 is 1 edge.
- Widths:
  - Phase counter is PER_W bits, compared for equality, never wraps in normal operation.
  - beat_cnt is 8-bit modulo-256.
- busy = (state != IDLE), registered with the state.
- No output glitches: all outputs are flops.

Test Plan:
1. Reset, en=1 with defaults -> beat rises 1 edge after en. High 4 cycles, rising edges every 1000 cycles. beat_cnt=3 after the 3rd rise. err=0.
2. load period_in=10, width_in=3 mid-LOW -> current beat keeps the 1000 period. The next beat starts the 10-cycle period / 3-cycle high. Edges 10 apart thereafter.
3. load period_in=2, width_in=5 -> clamped to width 5, period 6. err=1 and stays 1 after later legal loads. Separately, width_in=0 -> width 1.
4. en dropped in cycle 2 of a 3-cycle HIGH -> beat stays high through cycle 3, then 0, busy=0 next edge. Re-assert en -> new beat after 1 edge.
5. Run period 4, width 1 for 260 beats -> beat_cnt wraps to 4. Counter (1 s window) sees matching edges.
6. Assert reset during HIGH -> beat=0, busy=0, beat_cnt=0 asynchronously. After release, defaults are active (not the last loaded values).

Source files
------------

// File: rtl/hart_puls_gen.sv
// Programmable heartbeat pulse generator: periodic registered beat with run-time
// rate/width reload at beat boundaries, clamping of illegal settings and a beat counter.
module hart_puls_gen #(
    parameter int unsigned      PER_W      = 16,
    parameter logic [PER_W-1:0] DEF_PERIOD = PER_W'(1000),
    parameter logic [7:0]       DEF_WIDTH  = 8'd4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [PER_W-1:0] period_in,
    input  logic [7:0]       width_in,
    output logic             beat,
    output logic [7:0]       beat_cnt,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_t;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   cnt_q, cnt_d;
    logic [PER_W-1:0]   shd_per_q, act_per_q;
    logic [7:0]         shd_wid_q, act_wid_q;
    logic [7:0]         beat_cnt_q;
    logic               beat_q, busy_q, err_q;

    logic [PER_W-1:0]   src_per;
    logic [7:0]         src_wid;
    logic [7:0]         wid_eff;
    logic [PER_W-1:0]   wid_ext;
    logic [PER_W-1:0]   per_eff;
    logic               clamp;
    logic               start;

    // A load on the same edge as a beat start bypasses the shadow registers.
    always_comb begin
        src_per = load ? period_in : shd_per_q;
        src_wid = load ? width_in  : shd_wid_q;
        wid_eff = (src_wid == 8'd0) ? 8'd1 : src_wid;
        wid_ext = PER_W'(wid_eff);
        per_eff = (src_per <= wid_ext) ? wid_ext + PER_W'(1) : src_per;
        clamp   = (src_wid == 8'd0) || (src_per <= wid_ext);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    start = 1'b1;
                end
            end
            StHigh: begin
                if (cnt_q == PER_W'(act_wid_q)) begin
                    if (en) begin
                        state_d = StLow;
                        cnt_d   = cnt_q + PER_W'(1);
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + PER_W'(1);
                end
            end
            StLow: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == act_per_q) begin
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q + PER_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (start) begin
            state_d = StHigh;
            cnt_d   = PER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= (state_d == StHigh);
            busy_q  <= (state_d != StIdle);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_per_q <= DEF_PERIOD;
            shd_wid_q <= DEF_WIDTH;
        end else if (load) begin
            shd_per_q <= period_in;
            shd_wid_q <= width_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_per_q  <= DEF_PERIOD;
            act_wid_q  <= DEF_WIDTH;
            beat_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else if (start) begin
            act_per_q  <= per_eff;
            act_wid_q  <= wid_eff;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (clamp) begin
                err_q <= 1'b1;
            end
        end
    end

    assign beat     = beat_q;
    assign busy     = busy_q;
    assign beat_cnt = beat_cnt_q;
    assign err      = err_q;

endmodule
